// File: rtl/trans_arbiter_pkg.sv
// Shared translator definitions: channel-id width derivation and arbiter FSM states.
package trans_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic int cid_w(input int chans);
        return (chans <= 2) ? 1 : $clog2(chans);
    endfunction

endpackage

// File: rtl/trans_arbiter_rr_select.sv
// Cyclic priority pick: first requester at or above ptr, wrapping modulo CHANS.
module rr_select
    import trans_arbiter_pkg::*;
#(
    parameter int  CHANS = 4,
    localparam int CID_W = cid_w(CHANS)
) (
    input  logic [CHANS-1:0] req,
    input  logic [CID_W-1:0] ptr,
    output logic [CHANS-1:0] grant,
    output logic [CID_W-1:0] idx,
    output logic             any
);

    logic [CID_W-1:0] cand;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cand = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < CHANS; k++) begin
            cand = CID_W'((int'(ptr) + k) % CHANS);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
        grant = any ? (CHANS'(1) << idx) : '0;
    end

endmodule

// File: rtl/trans_arbiter.sv
// Packet-atomic round-robin merge of CHANS translation request streams onto one
// registered output stream, tagging each beat with its source channel.
module trans_arbiter
    import trans_arbiter_pkg::*;
#(
    parameter int  CHANS   = 4,
    parameter int  VADDR_W = 8,
    parameter int  BLOCK_W = 8,
    localparam int CID_W   = cid_w(CHANS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [CHANS-1:0]              s_tvalid,
    input  logic [CHANS-1:0]              s_tlast,
    input  logic [CHANS-1:0][VADDR_W-1:0] s_tdata,
    input  logic [CHANS-1:0][BLOCK_W-1:0] s_tuser,
    output logic [CHANS-1:0]              s_tready,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic [VADDR_W-1:0]            m_tdata,
    output logic [BLOCK_W-1:0]            m_tuser,
    output logic [CID_W-1:0]              m_tid,
    input  logic                          m_tready,
    output logic                          o_busy,
    output logic [15:0]                   o_pkt_cnt
);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CID_W-1:0] rr_ptr;
    logic [CID_W-1:0] lock_ch;
    logic [CID_W-1:0] gnt;
    logic [CHANS-1:0] sel_onehot;
    logic [CID_W-1:0] sel_idx;
    logic             sel_any;
    logic             out_free;
    logic             accept;
    logic             acc_last;

    rr_select #(
        .CHANS (CHANS)
    ) u_rr_select (
        .req   (s_tvalid),
        .ptr   (rr_ptr),
        .grant (sel_onehot),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // A held lock overrides arbitration even while the owner is bubbling.
    assign gnt      = (state == ST_LOCKED) ? lock_ch : sel_idx;
    assign out_free = !m_tvalid || m_tready;
    assign accept   = |(s_tvalid & s_tready);
    assign acc_last = s_tlast[gnt];

    // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && !acc_last) state_nxt = ST_LOCKED;
            ST_LOCKED: if (accept && acc_last)  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state == ST_LOCKED);
        s_tready = '0;
        if (i_rst_n && out_free) begin
            if (state == ST_LOCKED) begin
                s_tready = CHANS'(1) << lock_ch;
            end else if (sel_any) begin
                s_tready = sel_onehot;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else if (accept) begin
            lock_ch <= gnt;
            if (acc_last) begin
                rr_ptr <= (gnt == CID_W'(CHANS - 1)) ? '0 : gnt + CID_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= '0;
            m_tid    <= '0;
        end else if (accept) begin
            m_tvalid <= 1'b1;
            m_tlast  <= acc_last;
            m_tdata  <= s_tdata[gnt];
            m_tuser  <= s_tuser[gnt];
            m_tid    <= gnt;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_cnt <= '0;
        end else if (m_tvalid && m_tready && m_tlast) begin
            o_pkt_cnt <= o_pkt_cnt + 16'd1;
        end
    end

endmodule
